// File: rtl/aemb2_ifetch.sv
// AEMB2 instruction fetch stage: per-thread PCs, Wishbone-style instruction bus master,
// instruction field split, pipeline enable and thread-phase generation.
module aemb2_ifetch #(
  parameter bit          TXE  = 1'b1,
  parameter int unsigned IAW  = 16,
  parameter int unsigned RSTV = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,

  output logic           iwb_stb_o,
  output logic [IAW-3:0] iwb_adr_o,
  input  logic           iwb_ack_i,
  input  logic [31:0]    iwb_dat_i,

  input  logic [1:0]     bra_i,
  input  logic           bth_i,
  input  logic [IAW-3:0] bpc_i,
  input  logic           hzd_i,

  output logic           ena_o,
  output logic           pha_o,
  output logic [5:0]     rOPC_IF,
  output logic [4:0]     rRD_IF,
  output logic [4:0]     rRA_IF,
  output logic [4:0]     rRB_IF,
  output logic [10:0]    rALT_IF,
  output logic [15:0]    rIMM_IF,
  output logic [IAW-3:0] rPC_IF
);

  localparam int unsigned AW = IAW - 2;
  localparam logic [IAW-1:0] RstByte = IAW'(RSTV);
  localparam logic [AW-1:0]  RstWord = RstByte[IAW-1:2];

  typedef enum logic [0:0] {StRst, StFetch} state_e;

  state_e               state_q, state_d;
  logic [1:0][AW-1:0]   pc_q, pc_d;
  logic                 fth_q, fth_d;
  logic                 pha_q, pha_d;
  logic [31:0]          dat_q, dat_d;
  logic [AW-1:0]        rpc_q, rpc_d;

  logic                 bra_any;
  logic                 bth_eff;

  assign bra_any = |bra_i;
  // With a single thread every branch belongs to thread 0.
  assign bth_eff = TXE ? bth_i : 1'b0;

  assign iwb_stb_o = (state_q == StFetch);
  assign iwb_adr_o = pc_q[fth_q];
  assign ena_o     = iwb_stb_o & iwb_ack_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fth_d   = fth_q;
    pha_d   = pha_q;
    dat_d   = dat_q;
    rpc_d   = rpc_q;

    unique case (state_q)
      StRst:   state_d = StFetch;
      StFetch: state_d = StFetch;
      default: state_d = StRst;
    endcase

    if (ena_o) begin
      dat_d = iwb_dat_i;
      rpc_d = iwb_adr_o;
      pha_d = fth_q;
      // Branch on the fetching thread beats a hazard hold.
      if (bra_any && (bth_eff == fth_q)) begin
        pc_d[fth_q] = bpc_i;
      end else if (!hzd_i) begin
        pc_d[fth_q] = pc_q[fth_q] + AW'(1);
      end
      if (bra_any && (bth_eff != fth_q)) begin
        pc_d[bth_eff] = bpc_i;
      end
      if (TXE) begin
        fth_d = ~fth_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StRst;
      pc_q    <= {2{RstWord}};
      fth_q   <= 1'b0;
      pha_q   <= 1'b0;
      dat_q   <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fth_q   <= fth_d;
      pha_q   <= pha_d;
      dat_q   <= dat_d;
      rpc_q   <= rpc_d;
    end
  end

  assign pha_o   = pha_q;
  assign rOPC_IF = dat_q[31:26];
  assign rRD_IF  = dat_q[25:21];
  assign rRA_IF  = dat_q[20:16];
  assign rRB_IF  = dat_q[15:11];
  assign rALT_IF = dat_q[10:0];
  assign rIMM_IF = dat_q[15:0];
  assign rPC_IF  = rpc_q;

endmodule

// File: tb/tb_aemb2_ifetch.sv
// Bench for aemb2_ifetch: a single-thread instance (RSTV=0) and a two-thread instance
// (RSTV=0x100) share stimulus and are checked every cycle against a behavioural model.
module tb_aemb2_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ack;
  logic [31:0] dat;
  logic [1:0]  bra;
  logic        bth;
  logic [13:0] bpc;
  logic        hzd;

  logic        stb [2];
  logic [13:0] adr [2];
  logic        ena [2];
  logic        pha [2];
  logic [5:0]  opc [2];
  logic [4:0]  rd  [2];
  logic [4:0]  ra  [2];
  logic [4:0]  rb  [2];
  logic [10:0] alt [2];
  logic [15:0] imm [2];
  logic [13:0] rpc [2];

  int checks = 0;
  int failures = 0;

  // Behavioural model, one entry per instance (0: single thread, 1: two threads).
  bit          m_fetch [2];
  logic [13:0] m_pc    [2][2];
  bit          m_fth   [2];
  bit          m_pha   [2];
  logic [31:0] m_dat   [2];
  logic [13:0] m_rpc   [2];
  bit          m_valid = 1'b0;

  always #5 clk = ~clk;

  aemb2_ifetch #(.TXE(1'b0), .IAW(16), .RSTV(0)) u0 (
    .clk_i(clk), .rst_i(rst_n),
    .iwb_stb_o(stb[0]), .iwb_adr_o(adr[0]), .iwb_ack_i(ack), .iwb_dat_i(dat),
    .bra_i(bra), .bth_i(bth), .bpc_i(bpc), .hzd_i(hzd),
    .ena_o(ena[0]), .pha_o(pha[0]),
    .rOPC_IF(opc[0]), .rRD_IF(rd[0]), .rRA_IF(ra[0]), .rRB_IF(rb[0]),
    .rALT_IF(alt[0]), .rIMM_IF(imm[0]), .rPC_IF(rpc[0])
  );

  aemb2_ifetch #(.TXE(1'b1), .IAW(16), .RSTV(32'h100)) u1 (
    .clk_i(clk), .rst_i(rst_n),
    .iwb_stb_o(stb[1]), .iwb_adr_o(adr[1]), .iwb_ack_i(ack), .iwb_dat_i(dat),
    .bra_i(bra), .bth_i(bth), .bpc_i(bpc), .hzd_i(hzd),
    .ena_o(ena[1]), .pha_o(pha[1]),
    .rOPC_IF(opc[1]), .rRD_IF(rd[1]), .rRA_IF(ra[1]), .rRB_IF(rb[1]),
    .rALT_IF(alt[1]), .rIMM_IF(imm[1]), .rPC_IF(rpc[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d.stb", k), 32'(stb[k]), 32'(m_fetch[k]));
        if (m_fetch[k]) chk($sformatf("u%0d.adr", k), 32'(adr[k]), 32'(m_pc[k][m_fth[k]]));
        chk($sformatf("u%0d.ena", k), 32'(ena[k]), 32'(m_fetch[k] && ack));
        chk($sformatf("u%0d.pha", k), 32'(pha[k]), 32'(m_pha[k]));
        chk($sformatf("u%0d.opc", k), 32'(opc[k]), 32'(m_dat[k] >> 26));
        chk($sformatf("u%0d.rd", k),  32'(rd[k]),  (m_dat[k] >> 21) & 32'h1F);
        chk($sformatf("u%0d.ra", k),  32'(ra[k]),  (m_dat[k] >> 16) & 32'h1F);
        chk($sformatf("u%0d.rb", k),  32'(rb[k]),  (m_dat[k] >> 11) & 32'h1F);
        chk($sformatf("u%0d.alt", k), 32'(alt[k]), m_dat[k] & 32'h7FF);
        chk($sformatf("u%0d.imm", k), 32'(imm[k]), m_dat[k] & 32'hFFFF);
        chk($sformatf("u%0d.rpc", k), 32'(rpc[k]), 32'(m_rpc[k]));
      end
    end
  endtask

  // Apply the rules for the clock edge about to happen, using the inputs now on the pins.
  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      bit txe;
      bit t;
      bit b;
      txe = (k == 1);
      if (!rst_n) begin
        m_fetch[k]  = 1'b0;
        m_pc[k][0]  = (k == 1) ? 14'h40 : 14'h0;
        m_pc[k][1]  = m_pc[k][0];
        m_fth[k]    = 1'b0;
        m_pha[k]    = 1'b0;
        m_dat[k]    = '0;
        m_rpc[k]    = '0;
      end else if (!m_fetch[k]) begin
        m_fetch[k] = 1'b1;
      end else if (ack) begin
        t = m_fth[k];
        b = txe ? bth : 1'b0;
        m_dat[k] = dat;
        m_rpc[k] = m_pc[k][t];
        m_pha[k] = t;
        if (bra != 2'd0 && b == t) m_pc[k][t] = bpc;
        else if (!hzd)             m_pc[k][t] = 14'((int'(m_pc[k][t]) + 1) % 16384);
        if (bra != 2'd0 && b != t) m_pc[k][b] = bpc;
        if (txe) m_fth[k] = !t;
      end
    end
    if (!rst_n) m_valid = 1'b1;
  endtask

  task automatic drive(input logic r, input logic a, input logic [31:0] d, input logic [1:0] br,
                       input logic bt, input logic [13:0] bp, input logic hz);
    rst_n = r; ack = a; dat = d; bra = br; bth = bt; bpc = bp; hzd = hz;
    #1;
  endtask

  task automatic tick();
    compare_all();
    advance();
    @(negedge clk);
  endtask

  logic [31:0] w;
  logic [31:0] prev;

  initial begin
    prev = '0;
    // Reset; the ack seen while in reset must not accept.
    drive(1'b0, 1'b1, 32'h0, 2'd0, 1'b0, 14'h0, 1'b0); tick();
    drive(1'b0, 1'b1, 32'hDEADBEEF, 2'd0, 1'b0, 14'h0, 1'b0);
    chk("rst.stb0", 32'(stb[0]), 32'd0);
    chk("rst.ena0", 32'(ena[0]), 32'd0);
    chk("rst.rpc1", 32'(rpc[1]), 32'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 14'h0, 1'b0);
    chk("rel.stb1", 32'(stb[1]), 32'd0);
    tick();

    // Zero-wait fetches.
    for (int i = 0; i < 4; i++) begin
      w = 32'h1234_5678 + 32'(i) * 32'h0421_1111;
      drive(1'b1, 1'b1, w, 2'd0, 1'b0, 14'h0, 1'b0);
      chk("zw.adr0", 32'(adr[0]), 32'(i));
      chk("zw.adr1", 32'(adr[1]), 32'h40 + 32'(i / 2));
      chk("zw.ena0", 32'(ena[0]), 32'd1);
      if (i > 0) begin
        chk("zw.rpc0", 32'(rpc[0]), 32'(i - 1));
        chk("zw.opc0", 32'(opc[0]), prev >> 26);
        chk("zw.pha1", 32'(pha[1]), 32'((i - 1) & 1));
      end
      prev = w;
      tick();
    end
    drive(1'b1, 1'b1, $urandom, 2'd0, 1'b0, 14'h0, 1'b0);
    chk("adr4", 32'(adr[0]), 32'd4);
    tick();

    // Three wait states on address 5.
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b0, $urandom, 2'd0, 1'b0, 14'h0, 1'b0);
      chk("ws.adr0", 32'(adr[0]), 32'd5);
      chk("ws.ena0", 32'(ena[0]), 32'd0);
      chk("ws.rpc0", 32'(rpc[0]), 32'd4);
      tick();
    end
    drive(1'b1, 1'b1, $urandom, 2'd0, 1'b0, 14'h0, 1'b0); chk("adr5", 32'(adr[0]), 32'd5); tick();
    drive(1'b1, 1'b1, $urandom, 2'd0, 1'b0, 14'h0, 1'b0); chk("adr6", 32'(adr[0]), 32'd6); tick();

    // Hazard, then branch with hazard.
    drive(1'b1, 1'b1, $urandom, 2'd0, 1'b0, 14'h0, 1'b1); chk("hz.adr0", 32'(adr[0]), 32'd7); tick();
    drive(1'b1, 1'b1, $urandom, 2'd1, 1'b0, 14'h20, 1'b1);
    chk("hz.refetch0", 32'(adr[0]), 32'd7);
    chk("hz.adr1", 32'(adr[1]), 32'h44);
    tick();
    drive(1'b1, 1'b1, $urandom, 2'd0, 1'b0, 14'h0, 1'b0);
    chk("br.adr0", 32'(adr[0]), 32'h20);
    chk("br.adr1", 32'(adr[1]), 32'h43);
    tick();

    // Cross-thread non-delay branch to the last word, then wrap.
    drive(1'b1, 1'b1, $urandom, 2'd2, 1'b1, 14'h3FFF, 1'b0);
    chk("xb.adr1", 32'(adr[1]), 32'h20);
    chk("xb.adr0", 32'(adr[0]), 32'h21);
    tick();
    drive(1'b1, 1'b1, $urandom, 2'd0, 1'b0, 14'h0, 1'b0);
    chk("xb.tgt1", 32'(adr[1]), 32'h3FFF);
    chk("xb.tgt0", 32'(adr[0]), 32'h3FFF);
    tick();
    drive(1'b1, 1'b1, $urandom, 2'd0, 1'b0, 14'h0, 1'b0);
    chk("xb.inc1", 32'(adr[1]), 32'h21);
    chk("wrap0", 32'(adr[0]), 32'h0);
    tick();
    drive(1'b1, 1'b1, $urandom, 2'd0, 1'b0, 14'h0, 1'b0);
    chk("wrap1", 32'(adr[1]), 32'h0);
    tick();

    // Reset while a fetch is pending.
    drive(1'b1, 1'b0, $urandom, 2'd0, 1'b0, 14'h0, 1'b0); tick();
    drive(1'b0, 1'b0, $urandom, 2'd0, 1'b0, 14'h0, 1'b0);
    chk("mr.stb0", 32'(stb[0]), 32'd1);
    tick();
    drive(1'b0, 1'b1, $urandom, 2'd1, 1'b1, 14'h155, 1'b0);
    chk("mr.stb", 32'(stb[0]), 32'd0);
    chk("mr.ena", 32'(ena[1]), 32'd0);
    chk("mr.rpc", 32'(rpc[0]), 32'd0);
    chk("mr.opc", 32'(opc[1]), 32'd0);
    chk("mr.pha", 32'(pha[1]), 32'd0);
    tick();
    drive(1'b1, 1'b0, $urandom, 2'd0, 1'b0, 14'h0, 1'b0); tick();
    drive(1'b1, 1'b1, $urandom, 2'd0, 1'b0, 14'h0, 1'b0);
    chk("mr.adr0", 32'(adr[0]), 32'h0);
    chk("mr.adr1", 32'(adr[1]), 32'h40);
    chk("mr.stb1", 32'(stb[1]), 32'd1);
    tick();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(99) >= 2),
            ($urandom_range(99) < 70),
            $urandom,
            ($urandom_range(99) < 20) ? 2'($urandom_range(3, 1)) : 2'd0,
            1'($urandom),
            14'($urandom),
            ($urandom_range(99) < 15));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aemb2_ifetch.md
# aemb2_ifetch

Instruction fetch stage for the AEMB2 core, directly upstream of the instruction decode mux. It keeps one program counter per hardware thread and runs a Wishbone-style instruction-bus master. It splits each returned instruction word into the opcode/register/immediate fields the decoder consumes. It also generates the pipeline enable and the thread-phase signal used by every downstream stage.

## Interface
- `TXE`, 1: thread-interleave enable. 1 means two threads alternate; 0 means a single thread and `pha_o` is held at 0.
- `IAW`, 16: instruction byte-address width. Word-aligned, so bits [1:0] are implicit 0.
- `RSTV`, 0: reset PC, a byte address, identical for both threads.
- `clk_i` in 1: clock; all state on rising edge.
- `rst_i` in 1: one clock; reset is synchronous and active-low (`rst_i`=0 resets on the clock edge).
- `iwb_stb_o` out 1: fetch request strobe.
- `iwb_adr_o` out IAW-2: word address, `IAW-1:2`.
- `iwb_ack_i` in 1: fetch acknowledge; data valid in the same cycle.
- `iwb_dat_i` in 32: instruction word.
- `bra_i` in 2: branch from execute.
  - 2'o0: none.
  - 2'o1: delayed.
  - 2'o2: non-delay.
  - 2'o3: treated as 2'o1.
- `bth_i` in 1: thread owning the branch. Ignored when TXE=0, where thread 0 is used.
- `bpc_i` in IAW-2: branch target word address.
- `hzd_i` in 1: decode hazard. The instruction being accepted this cycle must be refetched.
- `ena_o` out 1: global pipeline enable.
- `pha_o` out 1: thread phase of the instruction in the IF registers.
- `rOPC_IF` out 6: iwb_dat_i[31:26].
- `rRD_IF` out 5: [25:21].
- `rRA_IF` out 5: [20:16].
- `rRB_IF` out 5: [15:11].
- `rALT_IF` out 11: [10:0].
- `rIMM_IF` out 16: [15:0].
- `rPC_IF` out IAW-2: word address of the instruction held in the IF registers.

## Operation
- State machine has two states, RST and FETCH.
- **RST**
  - Entered whenever `rst_i`=0 at a clock edge, from any state, including mid-transaction.
  - Reset values:
    - PC0 = PC1 = RSTV[IAW-1:2].
    - `pha_o`=0.
    - `iwb_stb_o`=0.
    - All `r*_IF`=0 and `rPC_IF`=0.
    - `ena_o`=0.
  - On the first edge with `rst_i`=1, go to FETCH.
- **FETCH**
  - `iwb_stb_o`=1.
  - `iwb_adr_o`=PC[n], where n is the fetch thread. The fetch thread is `!pha_o` when TXE=1, else 0. It is tracked by a registered `fth` bit that resets to 0.
  - Address and strobe stay stable until `iwb_ack_i`=1.
- **`ena_o`** = (state==FETCH) & `iwb_ack_i`, combinational. The decoder and all later stages advance only when `ena_o`=1.
- **Accept**: on an edge with `ena_o`=1, update in this order:
  - Capture the fields of `iwb_dat_i`.
  - Set `rPC_IF` = `iwb_adr_o`.
  - Set `pha_o` = `fth`.
  - Update PC[fth]:
    - Branch pending for this thread (`bra_i`≠0 and `bth_i`==fth): PC[fth] = `bpc_i`.
    - Otherwise, if `hzd_i`=1: PC[fth] unchanged, so the same word is refetched on that thread's next turn.
    - Otherwise: PC[fth] = PC[fth]+1, modulo 2^(IAW-2), so all-ones wraps to 0.
  - Branch to the other thread (`bth_i`≠fth): PC[`bth_i`] = `bpc_i`. The increment or hold on PC[fth] still applies.
  - If TXE=1, `fth` toggles.
- **Without an accept**, `bra_i`, `bth_i`, `bpc_i` and `hzd_i` are ignored. The upstream holds them until `ena_o` is asserted.
- **Simultaneous events**
  - Branch and hazard on the same thread: the branch wins.
  - Non-delay versus delayed branch: this block does not distinguish them, because squashing the wrong-path instruction is done downstream. Both encodings update the PC identically.
- `iwb_ack_i` while `iwb_stb_o`=0 (RST) is ignored and produces no accept.

## Timing
- All outputs except `ena_o` are registered.
- `iwb_adr_o` and `iwb_stb_o` derive only from registered state.
- Latency:
  - First request is asserted 1 cycle after reset release.
  - Fields are visible on `r*_IF` 1 cycle after the ack edge.
- Throughput:
  - With zero-wait acks, one instruction is accepted per cycle.
  - The new address is presented in the cycle immediately after each ack (back-to-back strobe, no idle cycle).
- Wait states: each cycle with `iwb_ack_i`=0 holds all state and deasserts `ena_o`.
- Branch redirect: the target address appears on the bus at the next fetch of the owning thread.
  - TXE=0: the very next cycle.
  - TXE=1: the cycle after next.

## Test plan
- **Reset then zero-wait acks, TXE=0, RSTV=0**
  - Addresses 0,1,2,3 on consecutive cycles.
  - `r*_IF` fields follow data one cycle later.
  - `ena_o`=1 every cycle after the first request.
- **TXE=1, RSTV=0x100, zero-wait**
  - Address sequence 0x40,0x40,0x41,0x41,…
  - `pha_o` alternates 0,1.
  - `rPC_IF` matches each word.
- **Wait states**
  - Ack delayed 3 cycles on address 5.
  - `iwb_adr_o` held at 5, `ena_o`=0 for 3 cycles, and IF registers unchanged.
- **Hazard and branch**
  - `hzd_i`=1 on accept of address 7 (TXE=0): next address is 7 again.
  - `bra_i`=2'o1, `bpc_i`=0x20 together with `hzd_i`=1: next address is 0x20.
- **Cross-thread branch and wrap**
  - TXE=1, accept on thread 0 with `bra_i`=2'o2, `bth_i`=1, `bpc_i`=0x3FFF: thread 0 increments, and thread 1's next fetch is 0x3FFF.
  - The following thread-1 fetch is at 0.
- **Reset mid-transaction**
  - `rst_i`=0 while stb=1 and ack pending: `iwb_stb_o`=0 next cycle and outputs at reset values.
  - Ack in that cycle is ignored.
  - Fetch restarts at RSTV after release.
